// File: rtl/instr_mem_boot.sv
// rtl/instr_mem_boot.sv - instruction memory with byte-serial boot loader and registered fetch port
module instr_mem_boot #(
    parameter int               ADDR_W = 16,
    parameter int               DEPTH  = 1024,
    parameter int               XLEN   = 32,
    parameter logic [XLEN-1:0]  NOP    = 32'h00000013
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_start,
    input  logic                      load_valid,
    input  logic [7:0]                load_byte,
    input  logic                      load_last,
    output logic                      load_ready,
    output logic                      load_done,
    output logic                      load_ovf,
    output logic [$clog2(DEPTH):0]    word_count,
    output logic                      busy,
    input  logic                      fetch_req,
    input  logic [ADDR_W-1:0]         fetch_addr,
    output logic [XLEN-1:0]           fetch_rdata,
    output logic                      fetch_valid,
    output logic                      fetch_fault
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CMP_W = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0]  mem [DEPTH];
    logic [XLEN-1:0]  asm_word;
    logic [XLEN-1:0]  wdata;
    logic [1:0]       lane;
    logic             accept;
    logic             word_end;
    logic             mem_full;
    logic             fetch_fire;
    logic             fetch_bad;
    logic [CMP_W-1:0] fetch_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                if (load_start) state_nxt = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_start) begin
                    state_nxt = LOAD;
                end else if (load_valid && load_last) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b0;
                if (load_start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A restart in the same cycle as a byte drops the byte.
    assign accept   = load_valid & load_ready & ~load_start;
    assign word_end = accept & ((lane == 2'd3) | load_last);
    assign mem_full = (word_count == CNT_W'(DEPTH));
    // Assembly register is kept zeroed above the current lane, so a padded partial word falls out naturally.
    assign wdata    = asm_word | (XLEN'(load_byte) << {lane, 3'b000});

    always_ff @(posedge clk) begin
        if (reset) begin
            lane       <= 2'd0;
            asm_word   <= '0;
            word_count <= '0;
            load_ovf   <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            load_done <= accept & load_last;
            if (load_start) begin
                lane       <= 2'd0;
                asm_word   <= '0;
                word_count <= '0;
                load_ovf   <= 1'b0;
            end else if (accept) begin
                if (word_end) begin
                    lane     <= 2'd0;
                    asm_word <= '0;
                    if (mem_full) begin
                        load_ovf <= 1'b1;
                    end else begin
                        word_count <= word_count + CNT_W'(1);
                    end
                end else begin
                    lane     <= lane + 2'd1;
                    asm_word <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && word_end && !mem_full) begin
            mem[word_count[IDX_W-1:0]] <= wdata;
        end
    end

    assign fetch_fire = fetch_req & (state == RUN);
    assign fetch_idx  = CMP_W'(fetch_addr[ADDR_W-1:2]);
    assign fetch_bad  = (fetch_addr[1:0] != 2'b00) | (fetch_idx >= CMP_W'(word_count));

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_rdata <= NOP;
        end else begin
            fetch_valid <= fetch_fire;
            fetch_fault <= fetch_fire & fetch_bad;
            if (fetch_fire) begin
                fetch_rdata <= fetch_bad ? NOP : mem[fetch_idx[IDX_W-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_boot.sv
// tb/tb_instr_mem_boot.sv - directed, table-driven bench for instr_mem_boot
module tb_instr_mem_boot;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic        load_ovf;
    logic [2:0]  word_count;
    logic        busy;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic [31:0] fetch_rdata;
    logic        fetch_valid;
    logic        fetch_fault;

    instr_mem_boot #(
        .ADDR_W (16),
        .DEPTH  (4),
        .XLEN   (32),
        .NOP    (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_ovf    (load_ovf),
        .word_count  (word_count),
        .busy        (busy),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_rdata (fetch_rdata),
        .fetch_valid (fetch_valid),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] rdata;
        logic        fault;
    } fvec_t;

    int          total  = 0;
    int          passed = 0;
    logic [7:0]  img [$];
    fvec_t       vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic load_img(input bit do_start, input int exp_count);
        if (do_start) begin
            load_start = 1'b1;
            tick();
            load_start = 1'b0;
            chk("load_ready_after_start", 32'(load_ready), 32'd1);
            chk("word_count_cleared", 32'(word_count), 32'd0);
            chk("ovf_cleared", 32'(load_ovf), 32'd0);
        end
        for (int i = 0; i < img.size(); i++) begin
            load_valid = 1'b1;
            load_byte  = img[i];
            load_last  = (i == img.size() - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("load_done_pulse", 32'(load_done), 32'd1);
        chk("busy_low_with_done", 32'(busy), 32'd0);
        chk("word_count", 32'(word_count), 32'(exp_count));
        tick();
        chk("load_done_single", 32'(load_done), 32'd0);
    endtask

    task automatic fetch_chk(input string name, input logic [15:0] addr,
                             input logic [31:0] exp_data, input logic exp_fault);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req  = 1'b0;
        chk({name, "_valid"}, 32'(fetch_valid), 32'd1);
        chk({name, "_rdata"}, fetch_rdata, exp_data);
        chk({name, "_fault"}, 32'(fetch_fault), 32'(exp_fault));
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_byte  = 8'h00;
        load_last  = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 16'h0000;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_ovf", 32'(load_ovf), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        chk("rst_fetch_rdata", fetch_rdata, NOP);

        fetch_req  = 1'b1;
        fetch_addr = 16'h0000;
        tick();
        fetch_req = 1'b0;
        chk("idle_fetch_ignored", 32'(fetch_valid), 32'd0);

        // Image 1: two full words
        img = '{8'h33, 8'h00, 8'h21, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
        load_img(1'b1, 2);

        vecs[0] = '{16'h0000, 32'h00210033, 1'b0};
        vecs[1] = '{16'h0004, 32'h00A00113, 1'b0};
        vecs[2] = '{16'h0002, NOP,          1'b1};
        vecs[3] = '{16'h0008, NOP,          1'b1};
        vecs[4] = '{16'h0005, NOP,          1'b1};
        vecs[5] = '{16'h0004, 32'h00A00113, 1'b0};
        for (int i = 0; i < 6; i++) begin
            fetch_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rdata, vecs[i].fault);
        end
        tick();
        chk("idle_cycle_no_valid", 32'(fetch_valid), 32'd0);
        chk("rdata_holds", fetch_rdata, 32'h00A00113);

        // Back-to-back fetches; reload requested alongside the third
        fetch_req  = 1'b1;
        fetch_addr = 16'h0000;
        tick();
        chk("b2b1_valid", 32'(fetch_valid), 32'd1);
        chk("b2b1_rdata", fetch_rdata, 32'h00210033);
        fetch_addr = 16'h0004;
        tick();
        chk("b2b2_valid", 32'(fetch_valid), 32'd1);
        chk("b2b2_rdata", fetch_rdata, 32'h00A00113);
        fetch_addr = 16'h0000;
        load_start = 1'b1;
        tick();
        fetch_req  = 1'b0;
        load_start = 1'b0;
        chk("b2b3_valid", 32'(fetch_valid), 32'd1);
        chk("b2b3_rdata", fetch_rdata, 32'h00210033);
        chk("reload_busy", 32'(busy), 32'd1);
        chk("reload_ready", 32'(load_ready), 32'd1);
        chk("reload_count_clear", 32'(word_count), 32'd0);
        tick();
        chk("reload_no_valid", 32'(fetch_valid), 32'd0);

        // Image 2: padded partial word
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        load_img(1'b0, 2);
        fetch_chk("img2_w1", 16'h0004, 32'h00000605, 1'b0);
        fetch_chk("img2_w0", 16'h0000, 32'h04030201, 1'b0);
        fetch_chk("img2_oob", 16'h0008, NOP, 1'b1);

        // Image 3: overflow of the 4-word memory
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(8'h10 + i));
        load_img(1'b1, 4);
        chk("ovf_set", 32'(load_ovf), 32'd1);
        fetch_chk("ovf_w3", 16'h000C, 32'h1F1E1D1C, 1'b0);
        fetch_chk("ovf_w0", 16'h0000, 32'h13121110, 1'b0);
        fetch_chk("ovf_oob", 16'h0010, NOP, 1'b1);

        // Reset in the middle of a load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("midrst_ovf_cleared", 32'(load_ovf), 32'd0);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_byte  = 8'(8'hE0 + i);
            tick();
        end
        load_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_word_count", 32'(word_count), 32'd0);
        chk("midrst_ready", 32'(load_ready), 32'd0);
        fetch_req  = 1'b1;
        fetch_addr = 16'h0000;
        tick();
        fetch_req = 1'b0;
        chk("midrst_fetch_ignored", 32'(fetch_valid), 32'd0);

        // Restart wins over a simultaneous byte
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_byte  = 8'h11;
        tick();
        load_byte  = 8'h22;
        tick();
        load_byte  = 8'h99;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        chk("restart_count_clear", 32'(word_count), 32'd0);
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load_img(1'b0, 1);
        fetch_chk("restart_w0", 16'h0000, 32'hDDCCBBAA, 1'b0);
        fetch_chk("restart_oob", 16'h0004, NOP, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_mem_boot.md
# instr_mem_boot

Parametrised instruction memory with a byte-serial boot loader and a registered fetch port. A host or UART front end streams a program image in little-endian bytes; the block packs them into XLEN-bit words and writes them sequentially from word 0. Once loading completes, the CPU fetch stage reads words with one-cycle latency. Misaligned fetches and fetches beyond the loaded image are flagged and return a NOP.

## Interface
Parameters:
- ADDR_W, 16: byte-address width of the fetch port.
- DEPTH, 1024: memory depth in words. Must be a power of 2 and no larger than 2^(ADDR_W-2).
- XLEN, 32: instruction width. Fixed at 32 in this generation.
- NOP, 32'h00000013: word returned on faulting fetches (ADDI x0,x0,0).

Ports (reset is synchronous and active-high):
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- load_start  in  1  one-cycle pulse; starts a new image load.
- load_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  image byte, little-endian within each word.
- load_last  in  1  qualifies the final byte of the image (with load_valid).
- load_ready  out  1  high in LOAD state only.
- load_done  out  1  one-cycle pulse when loading ends.
- load_ovf  out  1  sticky; image exceeded DEPTH words.
- word_count  out  $clog2(DEPTH)+1  number of words loaded.
- busy  out  1  high while not in RUN; the CPU must stall.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address (PC).
- fetch_rdata  out  XLEN  instruction word.
- fetch_valid  out  1  fetch_rdata is valid this cycle.
- fetch_fault  out  1  fault on the returned fetch.

## Operation
- FSM states: IDLE, LOAD, RUN. Reset enters IDLE.
- IDLE:
  - load_start → LOAD.
  - Fetches are ignored.
- LOAD:
  - On entry: word pointer, byte lane, word_count and load_ovf are cleared.
  - Each byte accepted (load_valid & load_ready) goes into the lane-th byte of the assembly register; lane then increments modulo 4.
  - When lane 3 is filled, the word is written to mem[ptr] and ptr increments.
  - On load_last, any partial word is written with its unfilled upper bytes set to 0. The FSM then goes to RUN and pulses load_done.
  - word_count = number of words written, including a padded partial word.
  - When ptr = DEPTH, further words are discarded and load_ovf is set. Bytes are still accepted until load_last, and word_count saturates at DEPTH.
  - load_start while already in LOAD restarts the load (same actions as on entry).
- RUN:
  - fetch_req samples fetch_addr; word index = fetch_addr[ADDR_W-1:2].
  - Misaligned fetch (fetch_addr[1:0] ≠ 0) → fault.
  - Index ≥ word_count → fault.
  - A faulting fetch returns NOP with fetch_fault=1.
  - A non-faulting fetch returns mem[index] with fetch_fault=0.
  - load_start in RUN → LOAD (reload). A fetch issued in that same cycle is still returned.
- Memory contents are not cleared by reset. Words not rewritten during a load are unreachable, because fetches beyond word_count fault.
- Simultaneous load_valid and load_start in LOAD: the restart wins and the byte is dropped.

## Timing
- Reset values:
  - State: IDLE.
  - load_ready=0, load_done=0, load_ovf=0, word_count=0, busy=1.
  - fetch_valid=0, fetch_fault=0, fetch_rdata=NOP.
- Fetch latency is 1 cycle. fetch_valid in cycle n+1 equals fetch_req & (state==RUN) in cycle n.
- The fetch port accepts one fetch per cycle with no backpressure. fetch_rdata holds its value when no fetch is returned.
- load_ready rises the cycle after load_start is sampled.
- A byte that completes a word is visible to fetches issued from the cycle after load_done.
- load_done is high for exactly one cycle, the same cycle in which busy falls.
- Reset asserted mid-load → IDLE next cycle. word_count=0 and the partial word is lost.

## Test plan
- Load bytes 33,00,21,00 | 13,01,A0,00 with load_last on the 8th byte → word_count=2 and load_done pulses once. Fetch 0x0 → 0x00210033; fetch 0x4 → 0x00A00113; each with fetch_valid one cycle later and fault=0.
- Load 6 bytes 01..06 with load_last on the 6th → word_count=2. Fetch 0x4 → 0x00000605.
- In RUN, fetch 0x2 → NOP with fault=1. Fetch 0x8 with word_count=2 → NOP with fault=1.
- DEPTH=4: stream 20 bytes → load_ovf=1, word_count=4, and fetch 0xC returns the 4th word.
- Assert reset after 3 bytes of a load → IDLE, busy=1, word_count=0. A subsequent fetch_req produces no fetch_valid.
- In RUN with back-to-back fetches 0x0, 0x4, 0x0: three consecutive valid responses. A load_start in the third cycle sends the block to LOAD; the third response is still delivered, then busy=1.
